button_cmd_scheduler: RTL and testbench
=======================================

BUTTON_CMD_SCHEDULER -- requirements
Module: button_cmd_scheduler

Interface
REQ-001 Parameter N_BTN, default 5: number of button inputs, range 2..8.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive cycles a changed raw level must persist before it is accepted, range 2..255.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-low reset.
REQ-005 Port btn, input, N_BTN: raw button levels, already synchronous to clk.
REQ-006 Port cmd_ready, input, 1: calculator datapath accepts the offered command.
REQ-007 Port cmd_valid, output, 1: a command is offered.
REQ-008 Port cmd_id, output, 3: index of the button that caused the offered command.
REQ-009 Port overrun, output, 1: sticky flag; a press was lost.

Function
REQ-010 Each button SHALL keep a debounced level and a debounce counter.
REQ-011 Debounce counter: clears whenever btn[i] equals the debounced level; otherwise increments.
REQ-012 The debounced level SHALL take the value of btn[i] on the DEB_CYCLES-th consecutive edge at which btn[i] differs from it; the counter clears on that same edge.
REQ-013 A 0->1 transition of the debounced level SHALL set pending[i] on the next edge; 1->0 transitions SHALL have no effect.
REQ-014 FSM states: IDLE, OFFER; encoding fixed in the package.
REQ-015 IDLE with pending non-zero: select the lowest set index, load cmd_id, clear that pending bit, assert cmd_valid, go to OFFER.
REQ-016 IDLE with pending zero: remain in IDLE, cmd_valid=0.
REQ-017 OFFER: cmd_valid and cmd_id SHALL stay constant until an edge with cmd_ready=1.
REQ-018 OFFER handshake with pending non-zero: load the next lowest index and remain in OFFER (back-to-back, no bubble).
REQ-019 OFFER handshake with pending zero: deassert cmd_valid and go to IDLE.
REQ-020 A new rising edge on a button whose pending bit is already set SHALL set overrun and leave pending[i]=1.
REQ-021 Overrun SHALL NOT be flagged when a button is offered; if its pending bit is cleared by selection on the same edge that a new rising edge sets it, pending[i] ends at 1.
REQ-022 A button whose command is currently offered (cmd_id=i) but whose pending bit is clear SHALL accept a new press into pending[i] without overrun.
REQ-023 cmd_ready while cmd_valid=0 SHALL be ignored.
REQ-024 Latency: with the FSM in IDLE, cmd_valid rises on edge DEB_CYCLES+2, counted from the first edge that samples the new high btn level.
REQ-025 Zero-extend cmd_id when N_BTN needs fewer than 3 bits.

Reset
REQ-026 With rst=0 at an edge: state=IDLE, pending=0, all debounced levels=0, all counters=0, cmd_valid=0, cmd_id=0, overrun=0.
REQ-027 Reset mid-offer SHALL drop the offered command and all pending presses without a handshake.
REQ-028 A button held high through reset release SHALL produce exactly one command, after DEB_CYCLES+2 edges.

Structure
REQ-029 Package calc_input_pkg SHALL hold: the FSM state typedef/encoding, CMD_ID_W=3, and default N_BTN/DEB_CYCLES constants.
REQ-030 Sub-module btn_debounce_edge SHALL contain one button's counter, debounced level and rising-edge pulse, and SHALL be instantiated N_BTN times via generate.
REQ-031 Priority selection, pending register, overrun and FSM SHALL reside in button_cmd_scheduler.

Verification (N_BTN=5, DEB_CYCLES=4)
REQ-032 btn[2] 0->1 held, cmd_ready=1 -> cmd_valid=1 with cmd_id=2 on edge 6 for exactly one cycle; no further command.
REQ-033 btn[3] pulses high for 3 cycles -> no command, debounced level remains 0.
REQ-034 btn[1] and btn[4] debounced on the same edge, cmd_ready=1 -> cmd_id=1 then cmd_id=4 on consecutive cycles, then cmd_valid=0.
REQ-035 btn[0] pressed, cmd_ready=0 for 20 cycles -> cmd_valid and cmd_id=0 held stable throughout; accepted on the first cmd_ready=1 edge.
REQ-036 btn[2] pressed twice while cmd_ready=0 and another command is offered -> overrun=1, held until rst=0; one command with cmd_id=2 is delivered.
REQ-037 rst=0 for one edge while in OFFER with 2 pending bits -> cmd_valid=0 and overrun=0 next cycle; no command is delivered until a new press.

Source files
------------

// File: rtl/calc_input_pkg.sv
// Shared types and constants for the calculator button front end.
package calc_input_pkg;

    localparam int CMD_ID_W       = 3;
    localparam int DEF_N_BTN      = 5;
    localparam int DEF_DEB_CYCLES = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } sched_state_t;

endpackage

// File: rtl/btn_debounce_edge.sv
// One button: consecutive-mismatch counter, accepted debounced level and a
// one-cycle pulse in the cycle after that level rises.
module btn_debounce_edge #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic [7:0] cnt;
    logic       level;
    logic       level_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            level_d <= level;
            if (btn == level) begin
                cnt <= '0;
            end else if (cnt == 8'(DEB_CYCLES - 1)) begin
                // this edge is the DEB_CYCLES-th consecutive mismatch
                level <= btn;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/button_cmd_scheduler.sv
// Debounces N_BTN buttons and offers one command per press over a
// valid/ready handshake, lowest button index first.
//
//   state    | meaning
//   ST_IDLE  | nothing offered, waiting for a pending press
//   ST_OFFER | cmd_valid high, cmd_id held until cmd_ready
module button_cmd_scheduler
    import calc_input_pkg::*;
#(
    parameter int N_BTN      = DEF_N_BTN,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BTN-1:0]    btn,
    input  logic                cmd_ready,
    output logic                cmd_valid,
    output logic [CMD_ID_W-1:0] cmd_id,
    output logic                overrun
);

    logic [N_BTN-1:0]    rise;
    logic [N_BTN-1:0]    pending;
    logic [N_BTN-1:0]    sel_mask;
    logic [N_BTN-1:0]    lost;
    logic [CMD_ID_W-1:0] sel_idx;
    logic                take;
    sched_state_t        state;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce_edge #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .btn (btn[g]),
            .rise(rise[g])
        );
    end

    always_comb begin
        sel_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending[i]) sel_idx = CMD_ID_W'(i);
        end
    end

    assign take     = (pending != '0) && ((state == ST_IDLE) || cmd_ready);
    assign sel_mask = take ? (N_BTN'(1) << sel_idx) : '0;
    // a bit being handed to the FSM this edge has room for the new press
    assign lost     = rise & pending & ~sel_mask;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pending   <= '0;
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
            overrun   <= 1'b0;
        end else begin
            pending <= (pending & ~sel_mask) | rise;
            if (lost != '0) overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        cmd_id    <= sel_idx;
                        cmd_valid <= 1'b1;
                        state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (cmd_ready) begin
                        if (take) begin
                            cmd_id <= sel_idx;
                        end else begin
                            cmd_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed and random stimulus for button_cmd_scheduler, compared each cycle
// against a rule-level model of debounce, pending presses and the offer queue.
module tb_button_cmd_scheduler;

    localparam int N   = 5;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic         cmd_ready;
    logic         cmd_valid;
    logic [2:0]   cmd_id;
    logic         overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_lvl[N];
    int m_cnt[N];
    bit m_rise[N];
    bit m_pend[N];
    bit m_valid;
    int m_id;
    bit m_ovr;

    int hs_id[$];
    int hs_t[$];

    button_cmd_scheduler #(.N_BTN(N), .DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_id   (cmd_id),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic rdy, input logic r);
        bit sel;
        bit any;
        int s;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                m_lvl[i] = 0; m_cnt[i] = 0; m_rise[i] = 0; m_pend[i] = 0;
            end
            m_valid = 0; m_id = 0; m_ovr = 0;
        end else begin
            sel = 0; any = 0; s = 0;
            for (int i = N - 1; i >= 0; i--) if (m_pend[i]) begin any = 1; s = i; end
            if (!m_valid) begin
                if (any) sel = 1;
            end else if (rdy) begin
                if (any) sel = 1;
                else m_valid = 0;
            end
            if (sel) begin m_id = s; m_valid = 1; end
            for (int i = 0; i < N; i++)
                if (m_rise[i] && m_pend[i] && !(sel && s == i)) m_ovr = 1;
            if (sel) m_pend[s] = 0;
            for (int i = 0; i < N; i++) if (m_rise[i]) m_pend[i] = 1;
            for (int i = 0; i < N; i++) begin
                m_rise[i] = 0;
                if (int'(b[i]) == m_lvl[i]) m_cnt[i] = 0;
                else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB) begin
                        m_lvl[i] = int'(b[i]);
                        m_cnt[i] = 0;
                        if (m_lvl[i] == 1) m_rise[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        if (rst === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            hs_id.push_back(int'(cmd_id));
            hs_t.push_back(cyc + 1);
        end
        @(posedge clk);
        cyc++;
        model_step(btn, cmd_ready, rst);
        #1;
        check("cmd_valid", int'(cmd_valid), int'(m_valid));
        check("cmd_id", int'(cmd_id), m_id);
        check("overrun", int'(overrun), int'(m_ovr));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int first;
        rst = 1'b0; btn = '0; cmd_ready = 1'b0;
        run(2);
        check("reset_valid", int'(cmd_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b1;
        run(2);

        // single press, latency and exactly one command
        hs_id.delete(); hs_t.delete();
        btn = 5'b00100; cmd_ready = 1'b1; first = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (cmd_valid === 1'b1 && first == 0) first = k;
        end
        check("latency_btn2", first, DEB + 2);
        check("one_cmd_btn2", hs_id.size(), 1);
        if (hs_id.size() > 0) check("id_btn2", hs_id[0], 2);
        btn = '0; run(8);

        // glitch shorter than the debounce window
        hs_id.delete();
        btn = 5'b01000; run(3);
        btn = '0; run(12);
        check("glitch_no_cmd", hs_id.size(), 0);

        // two buttons debounced together go out back to back
        hs_id.delete(); hs_t.delete();
        btn = 5'b10010; run(12);
        check("dual_count", hs_id.size(), 2);
        if (hs_id.size() == 2) begin
            check("dual_first", hs_id[0], 1);
            check("dual_second", hs_id[1], 4);
            check("dual_gap", hs_t[1] - hs_t[0], 1);
        end
        btn = '0; run(8);

        // long stall then accept
        hs_id.delete();
        cmd_ready = 1'b0; btn = 5'b00001; run(6);
        run(20);
        check("stall_valid", int'(cmd_valid), 1);
        check("stall_id", int'(cmd_id), 0);
        cmd_ready = 1'b1; run(3);
        check("stall_accept", hs_id.size(), 1);
        btn = '0; run(8);

        // double press of btn2 while btn1 is stalled
        hs_id.delete();
        cmd_ready = 1'b0; btn = 5'b00010; run(8);
        btn = 5'b00110; run(6);
        btn = 5'b00010; run(6);
        btn = 5'b00110; run(6);
        check("overrun_set", int'(overrun), 1);
        btn = '0; cmd_ready = 1'b1; run(10);
        check("overrun_cmds", hs_id.size(), 2);
        if (hs_id.size() == 2) check("overrun_btn2_once", hs_id[1], 2);
        check("overrun_sticky", int'(overrun), 1);
        do_reset();
        check("overrun_cleared", int'(overrun), 0);
        run(2);

        // reset during an offer with two pending presses
        cmd_ready = 1'b0; btn = 5'b00001; run(7);
        btn = 5'b00111; run(7);
        rst = 1'b0; btn = '0; tick(); rst = 1'b1;
        check("rst_drop_valid", int'(cmd_valid), 0);
        check("rst_drop_ovr", int'(overrun), 0);
        hs_id.delete();
        cmd_ready = 1'b1; run(15);
        check("rst_drop_nocmd", hs_id.size(), 0);

        // button held through reset release
        hs_id.delete();
        btn = 5'b01000; rst = 1'b0; tick(); rst = 1'b1;
        first = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (cmd_valid === 1'b1 && first == 0) first = k;
        end
        check("held_latency", first, DEB + 2);
        check("held_one_cmd", hs_id.size(), 1);
        btn = '0; run(8);

        // random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 4) == 0) btn[$urandom_range(0, N - 1)] ^= 1'b1;
            cmd_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
